// File: rtl/mux_func_pkg.sv
// Shared types and constants for the mux-built function sequencer and its benches.
package mux_func_pkg;

    localparam int NUM_VEC = 16;
    localparam int VEC_W   = 4;
    localparam int ERR_W   = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/mux_func_golden.sv
// Reference function Y = B & C & (A | D) for a stimulus vector {A,B,C,D}.
module mux_func_golden
    import mux_func_pkg::*;
(
    input  logic [VEC_W-1:0] abcd,
    output logic             expected
);

    assign expected = abcd[2] & abcd[1] & (abcd[3] | abcd[0]);

endmodule

// File: rtl/mux_func_sequencer.sv
// Walks all 16 input combinations through an external mux-built function,
// lets each one settle, then scores Y against the golden function.
module mux_func_sequencer
    import mux_func_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             y_in,
    output logic [VEC_W-1:0] abcd,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [VEC_W-1:0] first_fail,
    output logic             fail_valid
);

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VEC - 1);

    state_t           state, state_nx;
    logic [3:0]       settle_cnt, settle_cnt_nx;
    logic [VEC_W-1:0] abcd_nx, first_fail_nx;
    logic [ERR_W-1:0] err_nx;
    logic             busy_nx, done_nx, pass_nx, fail_valid_nx;
    logic             expected, mismatch;

    mux_func_golden u_golden (
        .abcd     (abcd),
        .expected (expected)
    );

    // Abort wins over the sample taken in the same cycle; outputs are all
    // derived from next-state values so every output leaves a flop.
    always_comb begin
        state_nx      = state;
        settle_cnt_nx = settle_cnt;
        abcd_nx       = abcd;
        pass_nx       = pass;
        err_nx        = err_count;
        first_fail_nx = first_fail;
        fail_valid_nx = fail_valid;
        mismatch      = (y_in != expected);

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx      = WAIT;
                    settle_cnt_nx = '0;
                    abcd_nx       = '0;
                    err_nx        = '0;
                    first_fail_nx = '0;
                    fail_valid_nx = 1'b0;
                    pass_nx       = 1'b0;
                end
            end
            WAIT: begin
                settle_cnt_nx = settle_cnt + 1'b1;
                if (abort) begin
                    state_nx = DONE;
                    pass_nx  = 1'b0;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nx = SAMPLE;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_nx = DONE;
                    pass_nx  = 1'b0;
                end else begin
                    if (mismatch) begin
                        err_nx = err_count + 1'b1;
                        if (!fail_valid) begin
                            first_fail_nx = abcd;
                            fail_valid_nx = 1'b1;
                        end
                    end
                    if (abcd == LAST_VEC) begin
                        state_nx = DONE;
                        pass_nx  = (err_nx == '0);
                    end else begin
                        state_nx      = WAIT;
                        abcd_nx       = abcd + 1'b1;
                        settle_cnt_nx = '0;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        busy_nx = (state_nx == WAIT) || (state_nx == SAMPLE);
        done_nx = (state_nx == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
            abcd       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            fail_valid <= 1'b0;
        end else begin
            state      <= state_nx;
            settle_cnt <= settle_cnt_nx;
            abcd       <= abcd_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            pass       <= pass_nx;
            err_count  <= err_nx;
            first_fail <= first_fail_nx;
            fail_valid <= fail_valid_nx;
        end
    end

endmodule
